// File: rtl/wm_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// wm_cycle_ctrl
//
// Washing-machine program sequencer. It steps FILL -> WASH -> RINSE(xN) -> DRY
// -> DONE, advancing on the shared 1 s tick. For each phase LED it produces a
// 2-bit display code that the downstream LED display stage turns into pins.
//
// Optional feature (compile-time macro WM_PAUSE_EN):
//   When WM_PAUSE_EN is defined, a pause pulse while busy toggles a pause.
//   While paused, ticks are ignored and the active phase LED shows steady (1).
//   When WM_PAUSE_EN is undefined, the pause input is ignored and paused is 0.
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  asynchronous reset, active-high
//   tick_1s      in   1  one-cycle enable, once per second
//   start        in   1  one-cycle start pulse (debounced upstream)
//   stop         in   1  one-cycle abort pulse
//   pause        in   1  one-cycle pause-toggle pulse (only with WM_PAUSE_EN)
//   water_sel    in   2  0=low 1=mid 2=high 3=high
//   repeat_sel   in   2  rinse passes = repeat_sel+1, 3 treated as 2
//   led_wash     out  2  wash LED code   (0=OFF 1=ON 2=BLINK)
//   led_rinse    out  2  rinse LED code
//   led_dry      out  2  dry LED code
//   busy         out  1  high in FILL/WASH/RINSE/DRY
//   paused       out  1  pause active
//   done_pulse   out  1  one-cycle pulse on the DRY->DONE transition
//   sec_left     out  8  seconds remaining in the current state, 0 in IDLE
//   rinse_left   out  2  rinse passes remaining incl. current, 0 outside RINSE
//   dbg_state    out  3  current FSM state encoding (debug observation only)
//
// Control inputs are single-cycle pulses sampled on every rising clk edge;
// there is no handshake. Priority within one cycle: stop > start > tick.
// -----------------------------------------------------------------------------
module wm_cycle_ctrl #(
    parameter int unsigned FILL_SEC  = 2,
    parameter int unsigned WASH_SEC  = 10,
    parameter int unsigned RINSE_SEC = 6,
    parameter int unsigned DRY_SEC   = 8,
    parameter int unsigned DONE_SEC  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] water_sel,
    input  logic [1:0] repeat_sel,
    output logic [1:0] led_wash,
    output logic [1:0] led_rinse,
    output logic [1:0] led_dry,
    output logic       busy,
    output logic       paused,
    output logic       done_pulse,
    output logic [7:0] sec_left,
    output logic [1:0] rinse_left,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_DRY   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] FILL_T1 = 8'(FILL_SEC);
    localparam logic [7:0] FILL_T2 = 8'(FILL_SEC * 2);
    localparam logic [7:0] FILL_T3 = 8'(FILL_SEC * 3);
    localparam logic [7:0] WASH_T  = 8'(WASH_SEC);
    localparam logic [7:0] RINSE_T = 8'(RINSE_SEC);
    localparam logic [7:0] DRY_T   = 8'(DRY_SEC);
    localparam logic [7:0] DONE_T  = 8'(DONE_SEC);

    localparam logic [1:0] LED_OFF   = 2'd0;
    localparam logic [1:0] LED_ON    = 2'd1;
    localparam logic [1:0] LED_BLINK = 2'd2;

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] rinse_left_q, rinse_left_d;
    logic [1:0] rep_q, rep_d;
    logic       paused_q, paused_d;
    logic       done_pulse_q, done_pulse_d;
    logic       busy_q, busy_d;
    logic [5:0] leds_q, leds_d;

    logic       pause_ev;
    logic [7:0] fill_time;
    logic [1:0] rep_norm;

`ifdef WM_PAUSE_EN
    assign pause_ev = pause;
`else
    // Pause feature compiled out: the toggle never fires, so paused stays 0.
    logic unused_pause;
    assign unused_pause = pause;
    assign pause_ev     = 1'b0;
`endif

    // Water level only shapes the FILL duration, which is loaded at start,
    // so the level is captured in the timer itself rather than a separate latch.
    always_comb begin
        case (water_sel)
            2'd0:    fill_time = FILL_T1;
            2'd1:    fill_time = FILL_T2;
            default: fill_time = FILL_T3;
        endcase
    end

    assign rep_norm = (repeat_sel == 2'd3) ? 2'd2 : repeat_sel;

    // LED codes for a given state; the active phase drops from blink to
    // steady while paused.
    function automatic logic [5:0] leds_for(input state_t s, input logic pz);
        logic [1:0] act;
        act = pz ? LED_ON : LED_BLINK;
        case (s)
            S_FILL,
            S_WASH:  leds_for = {act, LED_ON, LED_ON};
            S_RINSE: leds_for = {LED_OFF, act, LED_ON};
            S_DRY:   leds_for = {LED_OFF, LED_OFF, act};
            S_DONE:  leds_for = {LED_OFF, LED_OFF, LED_OFF};
            default: leds_for = {LED_ON, LED_ON, LED_ON};
        endcase
    endfunction

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        rinse_left_d = rinse_left_q;
        rep_d        = rep_q;
        paused_d     = paused_q;
        done_pulse_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // stop also wins here: start+stop in IDLE stays IDLE
                if (start && !stop) begin
                    state_d = S_FILL;
                    timer_d = fill_time;
                    rep_d   = rep_norm;
                end
            end

            S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    timer_d = 8'd0;
                end else if (start) begin
                    state_d = S_FILL;
                    timer_d = fill_time;
                    rep_d   = rep_norm;
                end else if (tick_1s) begin
                    if (timer_q > 8'd1) begin
                        timer_d = timer_q - 8'd1;
                    end else begin
                        state_d = S_IDLE;
                        timer_d = 8'd0;
                    end
                end
            end

            S_FILL, S_WASH, S_RINSE, S_DRY: begin
                if (stop) begin
                    state_d      = S_IDLE;
                    timer_d      = 8'd0;
                    rinse_left_d = 2'd0;
                    paused_d     = 1'b0;
                end else begin
                    if (pause_ev) begin
                        paused_d = ~paused_q;
                    end
                    // The tick is gated by the pause state held before this
                    // edge, so a pause pulse and tick together still count.
                    if (tick_1s && !paused_q) begin
                        if (timer_q > 8'd1) begin
                            timer_d = timer_q - 8'd1;
                        end else begin
                            case (state_q)
                                S_FILL: begin
                                    state_d = S_WASH;
                                    timer_d = WASH_T;
                                end
                                S_WASH: begin
                                    state_d      = S_RINSE;
                                    timer_d      = RINSE_T;
                                    rinse_left_d = rep_q + 2'd1;
                                end
                                S_RINSE: begin
                                    if (rinse_left_q > 2'd1) begin
                                        rinse_left_d = rinse_left_q - 2'd1;
                                        timer_d      = RINSE_T;
                                    end else begin
                                        state_d      = S_DRY;
                                        timer_d      = DRY_T;
                                        rinse_left_d = 2'd0;
                                    end
                                end
                                default: begin
                                    state_d      = S_DONE;
                                    timer_d      = DONE_T;
                                    done_pulse_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
            end

            default: begin
                // Illegal encoding: recover to a clean IDLE.
                state_d      = S_IDLE;
                timer_d      = 8'd0;
                rinse_left_d = 2'd0;
                paused_d     = 1'b0;
            end
        endcase

        // Outputs are computed from the next state so that they are plain
        // registers and change on the same edge as the state.
        busy_d = (state_d == S_FILL) || (state_d == S_WASH) ||
                 (state_d == S_RINSE) || (state_d == S_DRY);
        leds_d = leds_for(state_d, paused_d);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= 8'd0;
            rinse_left_q <= 2'd0;
            rep_q        <= 2'd0;
            paused_q     <= 1'b0;
            done_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            leds_q       <= {LED_ON, LED_ON, LED_ON};
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            rinse_left_q <= rinse_left_d;
            rep_q        <= rep_d;
            paused_q     <= paused_d;
            done_pulse_q <= done_pulse_d;
            busy_q       <= busy_d;
            leds_q       <= leds_d;
        end
    end

    assign led_wash   = leds_q[5:4];
    assign led_rinse  = leds_q[3:2];
    assign led_dry    = leds_q[1:0];
    assign busy       = busy_q;
    assign paused     = paused_q;
    assign done_pulse = done_pulse_q;
    assign sec_left   = timer_q;
    assign rinse_left = rinse_left_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wm_cycle_ctrl
//
// Directed bench for wm_cycle_ctrl with short durations
// (FILL_SEC=2 WASH_SEC=3 RINSE_SEC=2 DRY_SEC=3 DONE_SEC=2).
// A table of one-cycle vectors walks a full minimum program; hand-written
// sequences cover reset mid-cycle, long fill / three rinse passes, stop,
// input changes mid-cycle, restart from DONE and pause.
// -----------------------------------------------------------------------------
module tb_wm_cycle_ctrl;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1s, start, stop, pause;
    logic [1:0] water_sel, repeat_sel;
    logic [1:0] led_wash, led_rinse, led_dry;
    logic       busy, paused, done_pulse;
    logic [7:0] sec_left;
    logic [1:0] rinse_left;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    wm_cycle_ctrl #(
        .FILL_SEC (2),
        .WASH_SEC (3),
        .RINSE_SEC(2),
        .DRY_SEC  (3),
        .DONE_SEC (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1s   (tick_1s),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .water_sel (water_sel),
        .repeat_sel(repeat_sel),
        .led_wash  (led_wash),
        .led_rinse (led_rinse),
        .led_dry   (led_dry),
        .busy      (busy),
        .paused    (paused),
        .done_pulse(done_pulse),
        .sec_left  (sec_left),
        .rinse_left(rinse_left),
        .dbg_state (dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- driver tasks ----------------
    // Apply pulses for one clock, then sample #1 after the rising edge.
    task automatic step(input logic t, input logic s, input logic p, input logic pz);
        tick_1s = t;
        start   = s;
        stop    = p;
        pause   = pz;
        @(posedge clk);
        #1;
        tick_1s = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        pause   = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- scoreboard ----------------
    task automatic expect_out(input string name,
                              input logic [1:0] lw, input logic [1:0] lr, input logic [1:0] ld,
                              input logic b, input logic pz, input logic dp,
                              input logic [7:0] sl, input logic [1:0] rl);
        checks++;
        if (led_wash !== lw || led_rinse !== lr || led_dry !== ld || busy !== b ||
            paused !== pz || done_pulse !== dp || sec_left !== sl || rinse_left !== rl) begin
            failures++;
            $display("FAIL %s: got led=%0d/%0d/%0d busy=%0b paused=%0b done=%0b sec=%0d rinse=%0d, exp led=%0d/%0d/%0d busy=%0b paused=%0b done=%0b sec=%0d rinse=%0d",
                     name, led_wash, led_rinse, led_dry, busy, paused, done_pulse, sec_left, rinse_left,
                     lw, lr, ld, b, pz, dp, sl, rl);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       tick;
        logic       start;
        logic       stop;
        logic [1:0] lw, lr, ld;
        logic       busy;
        logic       done;
        logic [7:0] sec;
        logic [1:0] rl;
    } vec_t;

    vec_t vecs[17];
    int   done_seen;

    initial begin
        // Full program, water=0 repeat=0: FILL 2, WASH 3, RINSE 2, DRY 3, DONE 2
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 8'd2, 2'd0}; // start -> FILL
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 8'd1, 2'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 8'd3, 2'd0}; // -> WASH
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 8'd3, 2'd0}; // no tick, hold
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 8'd2, 2'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 8'd1, 2'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 1'b1, 1'b0, 8'd2, 2'd1}; // -> RINSE
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 1'b1, 1'b0, 8'd1, 2'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 8'd3, 2'd0}; // -> DRY
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 8'd2, 2'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 8'd1, 2'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 8'd2, 2'd0}; // 10th tick -> DONE
        vecs[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 8'd2, 2'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 8'd1, 2'd0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 8'd0, 2'd0}; // -> IDLE
        vecs[15] = '{1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 8'd0, 2'd0}; // tick in IDLE
        vecs[16] = '{1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 8'd0, 2'd0}; // stop in IDLE

        reset      = 1'b1;
        tick_1s    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        pause      = 1'b0;
        water_sel  = 2'd0;
        repeat_sel = 2'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_out("reset_state", 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("idle_after_reset", 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);

        // ---- table-driven full program ----
        done_seen = 0;
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].tick, vecs[i].start, vecs[i].stop, 1'b0);
            if (done_pulse) done_seen++;
            expect_out($sformatf("vec%0d", i), vecs[i].lw, vecs[i].lr, vecs[i].ld,
                       vecs[i].busy, 1'b0, vecs[i].done, vecs[i].sec, vecs[i].rl);
        end
        checks++;
        if (done_seen != 1) begin
            failures++;
            $display("FAIL done_pulse_count: got %0d exp 1", done_seen);
        end

        // ---- reset asserted mid-WASH ----
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        expect_out("mid_wash_before_reset", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd0);
        #2 reset = 1'b1;
        #1;
        expect_out("async_reset_mid_wash", 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        #1 reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("idle_after_mid_reset", 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);

        // ---- water=2 repeat=3: fill 6, three rinse passes ----
        water_sel  = 2'd2;
        repeat_sel = 2'd3;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("fill_high_start", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd6, 2'd0);
        ticks(5);
        expect_out("fill_high_last_sec", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd1, 2'd0);
        ticks(1);
        expect_out("fill_high_to_wash", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd3, 2'd0);
        ticks(3);
        expect_out("rinse_pass3", 2'd0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd3);
        ticks(2);
        expect_out("rinse_pass2", 2'd0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd2);
        ticks(2);
        expect_out("rinse_pass1", 2'd0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd1);
        ticks(1);
        expect_out("rinse_pass1_end", 2'd0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 8'd1, 2'd1);
        ticks(1);
        expect_out("rinse3_to_dry", 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd3, 2'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0); // stop beats tick
        expect_out("stop_in_dry", 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);

        // ---- stop after 2nd WASH tick; start+stop in IDLE; start beats tick ----
        water_sel  = 2'd0;
        repeat_sel = 2'd0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4);
        expect_out("wash_after_2_ticks", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd1, 2'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("stop_in_wash", 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        expect_out("start_stop_idle", 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("start_beats_tick", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("stop_in_fill", 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);

        // ---- settings and start ignored while busy; restart from DONE ----
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(2);
        water_sel  = 2'd3;
        repeat_sel = 2'd3;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("start_in_wash_ignored", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd3, 2'd0);
        ticks(3);
        expect_out("latched_repeat_one_pass", 2'd0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd1);
        ticks(2);
        expect_out("latched_to_dry", 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd3, 2'd0);
        ticks(3);
        expect_out("latched_to_done", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 8'd2, 2'd0);
        water_sel  = 2'd1;
        repeat_sel = 2'd1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("start_in_done", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd4, 2'd0);
        ticks(4);
        expect_out("mid_fill_to_wash", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd3, 2'd0);
        ticks(3);
        expect_out("new_repeat_two_passes", 2'd0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("stop_in_rinse", 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);

        // ---- pause ----
        water_sel  = 2'd0;
        repeat_sel = 2'd0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        expect_out("pause_setup_wash", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef WM_PAUSE_EN
        expect_out("pause_on", 2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0, 8'd2, 2'd0);
        ticks(5);
        expect_out("paused_timer_frozen", 2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0, 8'd2, 2'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("start_while_paused", 2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0, 8'd2, 2'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("pause_off", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd0);
        ticks(1);
        expect_out("resume_tick", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd1, 2'd0);
        ticks(1);
        expect_out("resume_to_rinse", 2'd0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("stop_clears_pause", 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
`else
        expect_out("pause_ignored", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd0);
        ticks(1);
        expect_out("pause_ignored_tick", 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 8'd1, 2'd0);
        ticks(1);
        expect_out("pause_ignored_to_rinse", 2'd0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 8'd2, 2'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("final_stop", 2'd1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
`endif

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
